// File: rtl/ram_rd_streamer_if.sv
// ----------------------------------------------------------------------------
// ram_rd_streamer_if
// Groups the two buses of the read streamer: the read side of a pipelined RAM
// port and the outgoing valid/ready word stream.
//   ram_en / ram_we / ram_addr   streamer -> RAM   read request (ram_we is 0)
//   ram_dout / ram_dout_valid    RAM -> streamer   fixed-latency read data
//   m_data / m_valid / m_last    streamer -> sink  stream word, last-of-burst
//   m_ready                      sink -> streamer  stream back-pressure
// master = streamer side, slave = RAM model / consumer side.
// ----------------------------------------------------------------------------
interface ram_rd_streamer_if #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 14
);
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic                  ram_dout_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_last;
   logic                  m_ready;

   modport master (
      output ram_en, ram_we, ram_addr, m_data, m_valid, m_last,
      input  ram_dout, ram_dout_valid, m_ready
   );

   modport slave (
      input  ram_en, ram_we, ram_addr, m_data, m_valid, m_last,
      output ram_dout, ram_dout_valid, m_ready
   );
endinterface

// File: rtl/ram_rd_streamer.sv
// ----------------------------------------------------------------------------
// ram_rd_streamer
// Burst read engine for one read-only RAM port. On an accepted start it reads
// base_addr .. base_addr+length-1, catches the RAM's non-stallable read data
// in a small first-word-fall-through FIFO and hands the words out as a
// valid/ready stream with a last flag. Reads are only issued while the reads
// in flight plus the words already buffered leave room in the FIFO, so the
// FIFO cannot overflow whatever the consumer does.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle burst request, ignored while busy
//   base_addr, length burst description, captured on the accepted start
//   busy, done        burst in progress / one-cycle completion pulse
//   ovf_err           sticky: read data arrived with nowhere to put it
//   bus               RAM read port and output stream (master modport)
// ----------------------------------------------------------------------------
module ram_rd_streamer #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 14,
   parameter int RD_LATENCY = 11,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf_err,
   ram_rd_streamer_if.master     bus
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   // A read is counted from the cycle it is decided until its data returns,
   // so at most RD_LATENCY+1 can be outstanding, and never more than the FIFO.
   localparam int OUT_MAX = (RD_LATENCY + 1 < FIFO_DEPTH) ? RD_LATENCY + 1 : FIFO_DEPTH;
   localparam int OUT_W   = $clog2(OUT_MAX + 1);
   localparam int SUM_W   = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t                state, state_next;
   logic                  issue;
   logic                  accept;
   logic                  credit_ok;
   logic [SUM_W-1:0]      in_use;
   logic                  ram_en_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [ADDR_WIDTH:0]   remaining;
   logic [ADDR_WIDTH:0]   wr_remaining;
   logic [OUT_W-1:0]      outstanding;
   logic                  ret;
   logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_empty, fifo_full;
   logic                  push, pop;
   logic [DATA_WIDTH:0]   head;

   assign accept     = (state == IDLE) && start;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && bus.m_ready;
   assign push       = bus.ram_dout_valid && (state != IDLE) && (!fifo_full || pop);
   assign ret        = bus.ram_dout_valid && (outstanding != '0);
   assign in_use     = SUM_W'(outstanding) + SUM_W'(fifo_count);
   assign credit_ok  = in_use < SUM_W'(FIFO_DEPTH);
   assign head       = fifo_mem[rd_ptr];

   assign bus.ram_en   = ram_en_q;
   assign bus.ram_we   = 1'b0;
   assign bus.ram_addr = ram_addr_q;
   assign bus.m_valid  = !fifo_empty;
   assign bus.m_data   = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
   assign bus.m_last   = !fifo_empty && head[DATA_WIDTH];
   assign busy         = (state != IDLE);
   assign done         = (state == FIN);

   // State register for the burst sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and issue decision. The first read is decided on the start
   // edge itself so ram_en appears the cycle after start; later reads need a
   // free FIFO slot counting both buffered words and reads still in flight.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               issue      = (length != '0);
               state_next = (length != '0) ? ISSUE : FIN;
            end
         end
         ISSUE: begin
            issue = (remaining != '0) && credit_ok;
            if (remaining == '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head[DATA_WIDTH]) begin
               state_next = FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered read port. ram_addr keeps the last issued address so the next
   // read is simply one more, wrapping at the top of the address space.
   // remaining counts reads still to be decided after the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_en_q   <= 1'b0;
         ram_addr_q <= '0;
         remaining  <= '0;
      end else begin
         ram_en_q <= issue;
         if (accept) begin
            ram_addr_q <= base_addr;
            remaining  <= (length == '0) ? '0 : length - 1'b1;
         end else if (issue) begin
            ram_addr_q <= ram_addr_q + 1'b1;
            remaining  <= remaining - 1'b1;
         end
      end
   end

   // Reads in flight: up on every issue, down on every returned word that
   // belongs to us. A stray return with nothing outstanding is left to ovf_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         case ({issue, ret})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // FIFO pointers, fill level, and the count of words still to arrive, which
   // tells the write side when it is storing the final word of the burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         wr_remaining <= '0;
      end else begin
         if (accept) begin
            wr_remaining <= length;
         end else if (push) begin
            wr_remaining <= wr_remaining - 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FIFO storage: data word plus its last-of-burst flag. The output is gated
   // by m_valid, so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {(wr_remaining == (ADDR_WIDTH+1)'(1)), bus.ram_dout};
      end
   end

   // Sticky overflow: read data that cannot be stored (FIFO full with no pop
   // in the same cycle, or no burst running) is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
      end else if (bus.ram_dout_valid && ((state == IDLE) || (fifo_full && !pop))) begin
         ovf_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// ----------------------------------------------------------------------------
// tb_ram_rd_streamer
// Drives ram_rd_streamer against a fixed-latency RAM model whose contents are
// a pure function of the address, and compares every stream word, issued
// address, handshake timing and status flag with what a burst of the given
// base and length must produce.
// ----------------------------------------------------------------------------
module tb_ram_rd_streamer;

   localparam int DATA_WIDTH = 36;
   localparam int ADDR_WIDTH = 14;
   localparam int RD_LATENCY = 11;
   localparam int FIFO_DEPTH = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   length;
   logic                  busy;
   logic                  done;
   logic                  ovf_err;
   logic                  ram_clr;
   logic [DATA_WIDTH:0]   pipe [RD_LATENCY];
   int                    cyc = 0;
   int                    compared = 0;
   int                    mismatched = 0;

   ram_rd_streamer_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   ram_rd_streamer #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RD_LATENCY(RD_LATENCY),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .base_addr(base_addr),
      .length(length),
      .busy(busy),
      .done(done),
      .ovf_err(ovf_err),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Cycle index; a value read at a falling edge names the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   // RAM contents: every address holds a distinct, recomputable word.
   function automatic logic [DATA_WIDTH-1:0] ram_word(input logic [ADDR_WIDTH-1:0] a);
      return {a, a[7:0] ^ 8'hA5, a ^ 14'h2AAA};
   endfunction

   // RAM read port: data and valid come out RD_LATENCY cycles after ram_en.
   // ram_clr empties the pipe, as a RAM reset along with the streamer would.
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {bus.ram_en, ram_word(bus.ram_addr)};
         for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign bus.ram_dout_valid = pipe[RD_LATENCY-1][DATA_WIDTH];
   assign bus.ram_dout       = pipe[RD_LATENCY-1][DATA_WIDTH-1:0];

   // One comparison: counts it, and on disagreement counts and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // All outputs must read zero (used while reset is asserted).
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_ovf_err"}, ovf_err, 0);
      checkOutput({tag, "_ram_en"}, bus.ram_en, 0);
      checkOutput({tag, "_ram_we"}, bus.ram_we, 0);
      checkOutput({tag, "_ram_addr"}, bus.ram_addr, 0);
      checkOutput({tag, "_m_valid"}, bus.m_valid, 0);
      checkOutput({tag, "_m_data"}, bus.m_data, 0);
      checkOutput({tag, "_m_last"}, bus.m_last, 0);
   endtask

   // Runs one burst and checks it cycle by cycle.
   //   mode 0: m_ready always 1; mode 1: random 50%; mode 2: 0 for 'stall' cycles then 1
   //   restart_at: cycle (after start) of an extra start pulse that must be ignored
   //   timed: also check exact issue and delivery cycles (needs mode 0, empty FIFO)
   task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] len,
                                input int mode, input int stall, input int restart_at, input bit timed);
      logic [ADDR_WIDTH-1:0] exp_addr;
      logic [DATA_WIDTH-1:0] prev_data;
      logic                  prev_last;
      bit                    prev_stall;
      bit                    finished;
      bit                    seen_valid;
      int                    s, issued, popped, last_hs, stall_en, budget;
      issued     = 0;
      popped     = 0;
      last_hs    = -10;
      stall_en   = 0;
      finished   = 1'b0;
      seen_valid = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      budget     = 4 * int'(len) + stall + 100;
      @(negedge clk);
      base_addr   = base;
      length      = len;
      start       = 1'b1;
      bus.m_ready = 1'b0;
      s           = cyc;
      for (int k = 1; k <= budget && !finished; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == restart_at) begin
            start     = 1'b1;
            base_addr = base + 14'h0155;
            length    = 15'd7;
         end
         case (mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = 1'($urandom_range(0, 1));
            default: bus.m_ready = (k > stall);
         endcase
         checkOutput("busy", busy, 1);
         checkOutput("ovf_err", ovf_err, 0);
         if (len == 0) begin
            checkOutput("done_len0", done, (cyc == s + 1));
         end else begin
            checkOutput("done", done, (popped == int'(len)) && (cyc == last_hs + 1));
         end
         if (done) finished = 1'b1;
         if (bus.ram_en) begin
            exp_addr = base + ADDR_WIDTH'(issued);
            checkOutput("ram_addr", bus.ram_addr, exp_addr);
            checkOutput("ram_we", bus.ram_we, 0);
            if (timed) checkOutput("issue_cycle", cyc - s, issued + 1);
            if (k <= stall) stall_en++;
            issued++;
         end
         if (prev_stall) begin
            checkOutput("hold_valid", bus.m_valid, 1);
            checkOutput("hold_data", bus.m_data, prev_data);
            checkOutput("hold_last", bus.m_last, prev_last);
         end
         if (bus.m_valid) begin
            if (!seen_valid && timed) checkOutput("first_valid_latency", cyc - s, RD_LATENCY + 2);
            seen_valid = 1'b1;
            if (bus.m_ready) begin
               exp_addr = base + ADDR_WIDTH'(popped);
               checkOutput("m_data", bus.m_data, ram_word(exp_addr));
               checkOutput("m_last", bus.m_last, popped == int'(len) - 1);
               if (timed) checkOutput("stream_cycle", cyc - s, RD_LATENCY + 2 + popped);
               popped++;
               last_hs = cyc;
            end
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
      end
      checkOutput("done_seen", finished, 1);
      checkOutput("issued_total", issued, len);
      checkOutput("popped_total", popped, len);
      if (stall > 0) checkOutput("stall_issue_count", stall_en, FIFO_DEPTH);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after", busy, 0);
      checkOutput("done_after", done, 0);
   endtask

   // Directed sequence: reset, the listed burst scenarios, random bursts,
   // then reset in the middle of a stalled burst.
   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      length      = '0;
      bus.m_ready = 1'b0;
      ram_clr     = 1'b1;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst_n   = 1'b1;
      ram_clr = 1'b0;
      @(negedge clk);

      $display("[TB] burst base 0x10 len 4, always ready, exact timing");
      applyStimulus(14'h0010, 15'd4, 0, 0, 0, 1'b1);

      $display("[TB] burst len 64, consumer stalled 100 cycles");
      applyStimulus(14'h0100, 15'd64, 2, 100, 0, 1'b0);

      $display("[TB] burst across the top of the address space");
      applyStimulus(14'h3FFE, 15'd4, 0, 0, 0, 1'b1);

      $display("[TB] zero-length burst");
      applyStimulus(14'h0200, 15'd0, 0, 0, 0, 1'b0);

      $display("[TB] len 1000, random ready, extra start mid-burst");
      applyStimulus(14'h0321, 15'd1000, 1, 0, 30, 1'b0);

      $display("[TB] random short bursts");
      for (int t = 0; t < 4; t++) begin
         applyStimulus(14'($urandom), 15'($urandom_range(1, 40)), 1, 0, 0, 1'b0);
      end

      $display("[TB] reset during a stalled burst");
      @(negedge clk);
      base_addr   = 14'h0440;
      length      = 15'd64;
      start       = 1'b1;
      bus.m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("pre_reset_busy", busy, 1);
      checkOutput("pre_reset_valid", bus.m_valid, 1);
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (RD_LATENCY + 4) @(negedge clk);
      checkOutput("stale_data_ovf_err", ovf_err, 1);
      checkOutput("stale_data_idle", busy, 0);
      ram_clr = 1'b1;
      rst_n   = 1'b0;
      @(negedge clk);
      checkOutput("ovf_err_cleared", ovf_err, 0);
      rst_n   = 1'b1;
      ram_clr = 1'b0;
      applyStimulus(14'h0500, 15'd20, 1, 0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
